lsu_stage: RTL and testbench
============================

// Module: lsu_stage
// PURPOSE
//  Memory stage between EXU and WBU. Latches one EXU result, issues at most one data-bus transaction
//  (load/store, RV32I widths), sign/zero-extends load data and hands the writeback payload to WBU.
//  Non-memory instructions pass through with one register stage. Moore FSM, one instruction in flight.
// PARAMETERS
//  TIMEOUT    256  cycles waited in S_RSP for rsp_valid before completing with bus_err (>=2)
//  CNT_W      9    width of timeout counter; must hold TIMEOUT
// PORTS
//  clk          in   1   clock, all state on posedge
//  rst          in   1   synchronous reset, active-low (0 = reset)
//  in_valid     in   1   EXU result valid
//  in_ready     out  1   LSU can accept (1 only in S_IDLE)
//  in_pc_target in   32  next PC from EXU
//  in_exu_res   in   32  ALU result / link value (writeback data for non-loads)
//  in_reg_wen   in   1   rd write enable
//  in_rd_addr   in   5   destination register
//  in_mem_en    in   1   instruction accesses memory
//  in_mem_wen   in   1   1 = store, 0 = load (meaningful only if in_mem_en)
//  in_mem_addr  in   32  byte address
//  in_mem_wdata in   32  store data (rs2), unshifted
//  in_funct3    in   3   access size/sign (000 B,001 H,010 W,100 BU,101 HU)
//  req_valid    out  1   bus request valid
//  req_ready    in   1   bus accepts request
//  req_addr     out  32  word-aligned address ({addr[31:2],2'b00})
//  req_wen      out  1   1 = write
//  req_wdata    out  32  store data shifted to byte lane
//  req_wstrb    out  4   byte strobes (0 for reads)
//  rsp_valid    in   1   bus response (read data or write ack), single-cycle pulse
//  rsp_rdata    in   32  read data, whole word
//  rsp_err      in   1   bus error, sampled with rsp_valid
//  out_valid    out  1   writeback payload valid
//  out_ready    in   1   WBU accepts
//  out_wb_data  out  32  data to write to rd
//  out_reg_wen  out  1   rd write enable (forced 0 on any error)
//  out_rd_addr  out  5   destination register
//  out_pc_target out 32  next PC, passed through
//  out_misalign out  1   access was misaligned; no bus transaction issued
//  out_bus_err  out  1   rsp_err seen or timeout expired
// BEHAVIOUR
//  Reset: state S_IDLE; in_ready=1 after reset released; req_valid=0, out_valid=0; all payload regs 0.
//  Input latched on in_valid&&in_ready; output payload registered; all handshake outputs decode state only.
//  States:
//   S_IDLE : in_ready=1. On fire: misaligned mem op or !mem_en -> S_WB; else -> S_REQ.
//   S_REQ  : req_valid=1, req_* stable while held. req_ready -> S_RSP, counter cleared.
//   S_RSP  : counter++ per cycle. rsp_valid -> capture result, S_WB. counter==TIMEOUT-1 w/o rsp -> S_WB, bus_err=1.
//   S_WB   : out_valid=1, payload stable. out_ready -> S_IDLE (no same-cycle accept of next input).
//  rsp_valid outside S_RSP is ignored (spurious). rsp_valid in the same cycle as timeout: response wins.
//  Misaligned: H with addr[0]=1, W with addr[1:0]!=0 -> out_misalign=1, out_reg_wen=0, no bus request.
//  Store lanes: B: wdata={4{wdata[7:0]}}, strb=4'b0001<<addr[1:0]; H: {2{wdata[15:0]}}, strb=4'b0011<<addr[1:0];
//   W: wdata as-is, strb=4'b1111. Unsupported funct3 (011,110,111) on mem op -> treated as misaligned.
//  Loads: byte/half selected by addr[1:0] from rsp_rdata, sign-ext (000/001) or zero-ext (100/101); W raw.
//  out_wb_data: load -> extended data; store -> in_exu_res (out_reg_wen=in_reg_wen, normally 0); else in_exu_res.
//  Errors (misalign, rsp_err, timeout) force out_reg_wen=0; out_wb_data=0 for errored loads.
//  Latency: non-mem fire cycle N -> out_valid N+1. Mem with req_ready=1 at N+1, rsp_valid at N+2 -> out_valid N+3.
//  rst=0 mid-transaction: returns to S_IDLE next edge, drops req_valid/out_valid; outstanding bus rsp ignored.
// TESTING
//  ALU op exu_res=0x1234, rd=5, mem_en=0 -> out_valid cycle after fire, wb_data=0x1234, reg_wen=1, no req_valid.
//  LB addr=0x103, rdata=0x80FF_FF7F -> req_addr=0x100, wstrb=0, wb_data=0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr=0x202 wdata=0xAAAA_BEEF -> req_wdata=0xBEEFBEEF, wstrb=4'b1100, req_wen=1; req_ready held 0 for 3 cycles -> req stable.
//  LW addr=0x301 -> no req_valid, out_misalign=1, out_reg_wen=0, out_valid next cycle.
//  LW with no rsp_valid -> out_bus_err=1 after TIMEOUT cycles in S_RSP; rsp_err=1 case -> bus_err=1, reg_wen=0.
//  out_ready=0 for 5 cycles in S_WB -> payload stable, in_ready=0; assert rst=0 during S_RSP -> S_IDLE, outputs reset.

Source files
------------

// File: rtl/lsu_stage.sv
`default_nettype none
// lsu_stage: memory stage between EXU and WBU; one instruction in flight, one bus access per load/store.
// Rev 1.0 - initial release.
module lsu_stage #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] in_pc_target_i,
  input  logic [31:0] in_exu_res_i,
  input  logic        in_reg_wen_i,
  input  logic [4:0]  in_rd_addr_i,
  input  logic        in_mem_en_i,
  input  logic        in_mem_wen_i,
  input  logic [31:0] in_mem_addr_i,
  input  logic [31:0] in_mem_wdata_i,
  input  logic [2:0]  in_funct3_i,
  output logic        req_valid_o,
  input  logic        req_ready_i,
  output logic [31:0] req_addr_o,
  output logic        req_wen_o,
  output logic [31:0] req_wdata_o,
  output logic [3:0]  req_wstrb_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_rdata_i,
  input  logic        rsp_err_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_wb_data_o,
  output logic        out_reg_wen_o,
  output logic [4:0]  out_rd_addr_o,
  output logic [31:0] out_pc_target_o,
  output logic        out_misalign_o,
  output logic        out_bus_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2,
    S_WB   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] exu_q, exu_d;
  logic        reg_wen_q, reg_wen_d;
  logic [4:0]  rd_q, rd_d;
  logic        mem_wen_q, mem_wen_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        wb_reg_wen_q, wb_reg_wen_d;
  logic        misalign_q, misalign_d;
  logic        bus_err_q, bus_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        in_misalign;
  logic [31:0] in_lane_data;
  logic [3:0]  in_lane_strb;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;

  // Unsupported access sizes are folded into the misaligned path.
  always_comb begin
    in_misalign  = 1'b0;
    in_lane_data = in_mem_wdata_i;
    in_lane_strb = 4'b1111;
    case (in_funct3_i)
      3'b000, 3'b100: begin
        in_lane_data = {4{in_mem_wdata_i[7:0]}};
        in_lane_strb = 4'b0001 << in_mem_addr_i[1:0];
      end
      3'b001, 3'b101: begin
        in_misalign  = in_mem_addr_i[0];
        in_lane_data = {2{in_mem_wdata_i[15:0]}};
        in_lane_strb = 4'b0011 << in_mem_addr_i[1:0];
      end
      3'b010: in_misalign = (in_mem_addr_i[1:0] != 2'b00);
      default: in_misalign = 1'b1;
    endcase
  end

  always_comb begin
    rd_shift = rsp_rdata_i >> {addr_q[1:0], 3'b000};
    case (funct3_q)
      3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
      3'b100:  load_ext = {24'h0, rd_shift[7:0]};
      3'b001:  load_ext = {{16{rd_shift[15]}}, rd_shift[15:0]};
      3'b101:  load_ext = {16'h0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    exu_d        = exu_q;
    reg_wen_d    = reg_wen_q;
    rd_d         = rd_q;
    mem_wen_d    = mem_wen_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    funct3_d     = funct3_q;
    wb_data_d    = wb_data_q;
    wb_reg_wen_d = wb_reg_wen_q;
    misalign_d   = misalign_q;
    bus_err_d    = bus_err_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          pc_d       = in_pc_target_i;
          exu_d      = in_exu_res_i;
          reg_wen_d  = in_reg_wen_i;
          rd_d       = in_rd_addr_i;
          mem_wen_d  = in_mem_en_i & in_mem_wen_i;
          addr_d     = in_mem_addr_i;
          funct3_d   = in_funct3_i;
          wdata_d    = in_lane_data;
          wstrb_d    = (in_mem_en_i && in_mem_wen_i) ? in_lane_strb : 4'b0000;
          misalign_d = 1'b0;
          bus_err_d  = 1'b0;
          cnt_d      = '0;
          if (!in_mem_en_i) begin
            wb_data_d    = in_exu_res_i;
            wb_reg_wen_d = in_reg_wen_i;
            state_d      = S_WB;
          end else if (in_misalign) begin
            misalign_d   = 1'b1;
            wb_reg_wen_d = 1'b0;
            wb_data_d    = in_mem_wen_i ? in_exu_res_i : 32'h0;
            state_d      = S_WB;
          end else begin
            wb_reg_wen_d = 1'b0;
            wb_data_d    = 32'h0;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (req_ready_i) begin
          cnt_d   = '0;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        cnt_d = cnt_q + CNT_W'(1);
        // A response arriving on the timeout cycle takes priority.
        if (rsp_valid_i) begin
          state_d = S_WB;
          if (rsp_err_i) begin
            bus_err_d    = 1'b1;
            wb_reg_wen_d = 1'b0;
            wb_data_d    = mem_wen_q ? exu_q : 32'h0;
          end else begin
            wb_reg_wen_d = reg_wen_q;
            wb_data_d    = mem_wen_q ? exu_q : load_ext;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d      = S_WB;
          bus_err_d    = 1'b1;
          wb_reg_wen_d = 1'b0;
          wb_data_d    = mem_wen_q ? exu_q : 32'h0;
        end
      end
      S_WB: begin
        if (out_ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      exu_q        <= '0;
      reg_wen_q    <= 1'b0;
      rd_q         <= '0;
      mem_wen_q    <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      funct3_q     <= '0;
      wb_data_q    <= '0;
      wb_reg_wen_q <= 1'b0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      exu_q        <= exu_d;
      reg_wen_q    <= reg_wen_d;
      rd_q         <= rd_d;
      mem_wen_q    <= mem_wen_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      funct3_q     <= funct3_d;
      wb_data_q    <= wb_data_d;
      wb_reg_wen_q <= wb_reg_wen_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready_o      = (state_q == S_IDLE);
  assign req_valid_o     = (state_q == S_REQ);
  assign out_valid_o     = (state_q == S_WB);
  assign req_addr_o      = {addr_q[31:2], 2'b00};
  assign req_wen_o       = mem_wen_q;
  assign req_wdata_o     = wdata_q;
  assign req_wstrb_o     = wstrb_q;
  assign out_wb_data_o   = wb_data_q;
  assign out_reg_wen_o   = wb_reg_wen_q;
  assign out_rd_addr_o   = rd_q;
  assign out_pc_target_o = pc_q;
  assign out_misalign_o  = misalign_q;
  assign out_bus_err_o   = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_stage.sv
`default_nettype none
// tb_lsu_stage: table-driven vectors plus hand-written multi-cycle sequences for lsu_stage.
module tb_lsu_stage;

  localparam int TIMEOUT = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] in_pc_target, in_exu_res;
  logic        in_reg_wen;
  logic [4:0]  in_rd_addr;
  logic        in_mem_en, in_mem_wen;
  logic [31:0] in_mem_addr, in_mem_wdata;
  logic [2:0]  in_funct3;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        out_valid, out_ready;
  logic [31:0] out_wb_data;
  logic        out_reg_wen;
  logic [4:0]  out_rd_addr;
  logic [31:0] out_pc_target;
  logic        out_misalign, out_bus_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lsu_stage #(.TIMEOUT(TIMEOUT), .CNT_W(9)) dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_pc_target_i(in_pc_target), .in_exu_res_i(in_exu_res),
    .in_reg_wen_i(in_reg_wen), .in_rd_addr_i(in_rd_addr),
    .in_mem_en_i(in_mem_en), .in_mem_wen_i(in_mem_wen),
    .in_mem_addr_i(in_mem_addr), .in_mem_wdata_i(in_mem_wdata),
    .in_funct3_i(in_funct3),
    .req_valid_o(req_valid), .req_ready_i(req_ready),
    .req_addr_o(req_addr), .req_wen_o(req_wen),
    .req_wdata_o(req_wdata), .req_wstrb_o(req_wstrb),
    .rsp_valid_i(rsp_valid), .rsp_rdata_i(rsp_rdata), .rsp_err_i(rsp_err),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_wb_data_o(out_wb_data), .out_reg_wen_o(out_reg_wen),
    .out_rd_addr_o(out_rd_addr), .out_pc_target_o(out_pc_target),
    .out_misalign_o(out_misalign), .out_bus_err_o(out_bus_err)
  );

  typedef struct {
    logic        mem_en;
    logic        mem_wen;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exu;
    logic        reg_wen;
    logic [31:0] rdata;
    logic        rsp_err;
    logic        exp_req;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wb;
    logic        exp_rwen;
    logic        exp_mis;
    logic        exp_err;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic mem_en, input logic mem_wen, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exu, input logic rwen, input logic [4:0] rd,
                       input logic [31:0] pc);
    in_valid = 1'b1; in_mem_en = mem_en; in_mem_wen = mem_wen; in_funct3 = f3;
    in_mem_addr = addr; in_mem_wdata = wdata; in_exu_res = exu;
    in_reg_wen = rwen; in_rd_addr = rd; in_pc_target = pc;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_vec(input int i, input vec_t v);
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] exp_addr;
    pc = 32'h1000 + 32'(i) * 32'd4;
    rd = 5'(i + 5);
    exp_addr = {v.addr[31:2], 2'b00};
    chk($sformatf("v%0d.in_ready", i), {31'h0, in_ready}, 32'd1);
    issue(v.mem_en, v.mem_wen, v.funct3, v.addr, v.wdata, v.exu, v.reg_wen, rd, pc);
    if (v.exp_req) begin
      chk($sformatf("v%0d.req_valid", i), {31'h0, req_valid}, 32'd1);
      chk($sformatf("v%0d.req_addr", i), req_addr, exp_addr);
      chk($sformatf("v%0d.req_wen", i), {31'h0, req_wen}, {31'h0, v.mem_wen});
      if (v.mem_wen) chk($sformatf("v%0d.req_wdata", i), req_wdata, v.exp_wdata);
      chk($sformatf("v%0d.req_wstrb", i), {28'h0, req_wstrb}, {28'h0, v.exp_wstrb});
      chk($sformatf("v%0d.early_out", i), {31'h0, out_valid}, 32'd0);
      req_ready = 1'b1;
      tick();
      req_ready = 1'b0;
      chk($sformatf("v%0d.req_drop", i), {31'h0, req_valid}, 32'd0);
      chk($sformatf("v%0d.rsp_out", i), {31'h0, out_valid}, 32'd0);
      rsp_valid = 1'b1; rsp_rdata = v.rdata; rsp_err = v.rsp_err;
      tick();
      rsp_valid = 1'b0; rsp_err = 1'b0;
    end else begin
      chk($sformatf("v%0d.no_req", i), {31'h0, req_valid}, 32'd0);
    end
    chk($sformatf("v%0d.out_valid", i), {31'h0, out_valid}, 32'd1);
    chk($sformatf("v%0d.wb_data", i), out_wb_data, v.exp_wb);
    chk($sformatf("v%0d.reg_wen", i), {31'h0, out_reg_wen}, {31'h0, v.exp_rwen});
    chk($sformatf("v%0d.rd", i), {27'h0, out_rd_addr}, {27'h0, rd});
    chk($sformatf("v%0d.pc", i), out_pc_target, pc);
    chk($sformatf("v%0d.misalign", i), {31'h0, out_misalign}, {31'h0, v.exp_mis});
    chk($sformatf("v%0d.bus_err", i), {31'h0, out_bus_err}, {31'h0, v.exp_err});
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk($sformatf("v%0d.out_drop", i), {31'h0, out_valid}, 32'd0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    // mem_en, mem_wen, funct3, addr, wdata, exu, reg_wen, rdata, rsp_err,
    // exp_req, exp_wdata, exp_wstrb, exp_wb, exp_rwen, exp_mis, exp_err
    vecs[0]  = '{1'b0, 1'b0, 3'b000, 32'h0,   32'h0,        32'h1234, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 32'h1234,     1'b1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h0,    1'b1, 32'h80FFFF7F, 1'b0, 1'b1, 32'h0,        4'h0, 32'hFFFFFF80, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h0,    1'b1, 32'h80FFFF7F, 1'b0, 1'b1, 32'h0,        4'h0, 32'h00000080, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h0,    1'b1, 32'h80FFFF7F, 1'b0, 1'b1, 32'h0,        4'h0, 32'hFFFF80FF, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 3'b101, 32'h100, 32'h0,        32'h0,    1'b1, 32'h12348001, 1'b0, 1'b1, 32'h0,        4'h0, 32'h00008001, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'b010, 32'h104, 32'h0,        32'h0,    1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h0,        4'h0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'b000, 32'h100, 32'h0,        32'h0,    1'b1, 32'h80FFFF7F, 1'b0, 1'b1, 32'h0,        4'h0, 32'h0000007F, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 3'b001, 32'h202, 32'hAAAABEEF, 32'h202,  1'b0, 32'h0,        1'b0, 1'b1, 32'hBEEFBEEF, 4'hC, 32'h202,      1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 3'b000, 32'h301, 32'h12345678, 32'h301,  1'b0, 32'h0,        1'b0, 1'b1, 32'h78787878, 4'h2, 32'h301,      1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h400,  1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D, 4'hF, 32'h400,      1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 3'b010, 32'h301, 32'h0,        32'h0,    1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 3'b001, 32'h103, 32'h0,        32'h9,    1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 3'b011, 32'h100, 32'h0,        32'h9,    1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 3'b010, 32'h108, 32'h0,        32'h0,    1'b1, 32'h11111111, 1'b1, 1'b1, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b1, 1'b1, 3'b001, 32'h201, 32'h1234,     32'h55,   1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 32'h55,       1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 3'b010, 32'h40C, 32'h99,       32'h77,   1'b1, 32'h0,        1'b1, 1'b1, 32'h99,       4'hF, 32'h77,       1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b0, 3'b110, 32'h3,   32'h0,        32'hABCD, 1'b1, 32'h0,        1'b0, 1'b0, 32'h0,        4'h0, 32'hABCD,     1'b1, 1'b0, 1'b0};

    rst = 1'b0; in_valid = 1'b0; in_pc_target = '0; in_exu_res = '0; in_reg_wen = 1'b0;
    in_rd_addr = '0; in_mem_en = 1'b0; in_mem_wen = 1'b0; in_mem_addr = '0;
    in_mem_wdata = '0; in_funct3 = '0; req_ready = 1'b0; rsp_valid = 1'b0;
    rsp_rdata = '0; rsp_err = 1'b0; out_ready = 1'b0;
    repeat (2) tick();
    chk("rst.req_valid", {31'h0, req_valid}, 32'd0);
    chk("rst.out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst.wb_data", out_wb_data, 32'h0);
    chk("rst.pc", out_pc_target, 32'h0);
    rst = 1'b1;
    tick();
    chk("rst.in_ready", {31'h0, in_ready}, 32'd1);

    for (int i = 0; i < 17; i++) run_vec(i, vecs[i]);

    // Store held off by req_ready=0; spurious rsp during S_REQ is ignored.
    issue(1'b1, 1'b1, 3'b001, 32'h202, 32'hAAAABEEF, 32'h0, 1'b0, 5'd3, 32'h2000);
    for (int k = 0; k < 3; k++) begin
      rsp_valid = (k == 1); rsp_rdata = 32'hFFFFFFFF;
      chk("hold.req_valid", {31'h0, req_valid}, 32'd1);
      chk("hold.req_addr", req_addr, 32'h200);
      chk("hold.req_wdata", req_wdata, 32'hBEEFBEEF);
      chk("hold.req_wstrb", {28'h0, req_wstrb}, 32'hC);
      chk("hold.in_ready", {31'h0, in_ready}, 32'd0);
      tick();
    end
    rsp_valid = 1'b0;
    chk("hold.req_valid4", {31'h0, req_valid}, 32'd1);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    rsp_valid = 1'b1; tick(); rsp_valid = 1'b0;
    chk("hold.out_valid", {31'h0, out_valid}, 32'd1);
    chk("hold.bus_err", {31'h0, out_bus_err}, 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Timeout with no response.
    issue(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h0, 1'b1, 5'd7, 32'h3000);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("tmo.cycles", 32'(cyc), 32'(TIMEOUT));
    chk("tmo.bus_err", {31'h0, out_bus_err}, 32'd1);
    chk("tmo.reg_wen", {31'h0, out_reg_wen}, 32'd0);
    chk("tmo.wb_data", out_wb_data, 32'h0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Response on the timeout cycle wins.
    issue(1'b1, 1'b0, 3'b010, 32'h504, 32'h0, 32'h0, 1'b1, 5'd8, 32'h3004);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    repeat (TIMEOUT - 1) tick();
    chk("race.pre_out", {31'h0, out_valid}, 32'd0);
    rsp_valid = 1'b1; rsp_rdata = 32'h600DF00D; tick(); rsp_valid = 1'b0;
    chk("race.out_valid", {31'h0, out_valid}, 32'd1);
    chk("race.bus_err", {31'h0, out_bus_err}, 32'd0);
    chk("race.wb_data", out_wb_data, 32'h600DF00D);
    chk("race.reg_wen", {31'h0, out_reg_wen}, 32'd1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Back-pressure in S_WB; a new input offered meanwhile is not accepted.
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'hC0FFEE, 1'b1, 5'd9, 32'h4000);
    in_valid = 1'b1; in_exu_res = 32'h1; in_pc_target = 32'h1;
    for (int k = 0; k < 5; k++) begin
      chk("bp.out_valid", {31'h0, out_valid}, 32'd1);
      chk("bp.wb_data", out_wb_data, 32'hC0FFEE);
      chk("bp.pc", out_pc_target, 32'h4000);
      chk("bp.in_ready", {31'h0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1; tick(); out_ready = 1'b0; in_valid = 1'b0;
    chk("bp.idle_in_ready", {31'h0, in_ready}, 32'd1);
    chk("bp.idle_out_valid", {31'h0, out_valid}, 32'd0);
    tick();
    chk("bp.no_accept", {31'h0, out_valid}, 32'd0);

    // Reset while waiting for a response; late response is ignored.
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0, 32'h0, 1'b1, 5'd10, 32'h5000);
    req_ready = 1'b1; tick(); req_ready = 1'b0;
    rst = 1'b0; tick();
    chk("mrst.in_ready", {31'h0, in_ready}, 32'd1);
    chk("mrst.req_valid", {31'h0, req_valid}, 32'd0);
    chk("mrst.out_valid", {31'h0, out_valid}, 32'd0);
    chk("mrst.pc", out_pc_target, 32'h0);
    rst = 1'b1;
    rsp_valid = 1'b1; rsp_rdata = 32'h12345678; tick(); rsp_valid = 1'b0;
    chk("mrst.late_rsp", {31'h0, out_valid}, 32'd0);
    chk("mrst.late_ready", {31'h0, in_ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
